// File: rtl/mult_shift_add.sv
// Iterative unsigned shift-and-add multiplier.
// One partial-product add per clock through a WIDTH-bit adder built from
// chained 4-bit carry-lookahead slices. The adder carry-out is shifted back
// into the accumulator every step, so a full 2*WIDTH-bit product is formed.

// ---------------------------------------------------------------------------
// 4-bit carry-lookahead slice. Besides the sum and carry-out it exports the
// group propagate/generate terms, so a higher level can compute the
// inter-slice carries without waiting on this slice's internal carries.
// ---------------------------------------------------------------------------
module cla4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout,
  output logic       grp_p,
  output logic       grp_g
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  // Bitwise propagate/generate, then fully expanded lookahead carries.
  always_comb begin
    p    = x ^ y;
    g    = x & y;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    sum   = p ^ c[3:0];
    cout  = c[4];
    grp_p = &p;
    grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
          | (p[3] & p[2] & p[1] & g[0]);
  end

endmodule

// ---------------------------------------------------------------------------
// WIDTH-bit adder: one cla4 slice per nibble. Slice carries are formed from
// the group P/G terms of the previous slice; the top carry is the adder
// carry-out and is never discarded. WIDTH must be a multiple of 4.
// ---------------------------------------------------------------------------
module cla_adder #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NSLICE = WIDTH / 4;

  logic [NSLICE:0]   slice_c;
  logic [NSLICE-1:0] slice_p;
  logic [NSLICE-1:0] slice_g;
  logic [NSLICE-1:0] slice_cout;

  assign slice_c[0] = cin;

  genvar gi;
  generate
    for (gi = 0; gi < NSLICE; gi = gi + 1) begin : g_slice
      cla4 u_cla4 (
        .x     (x[gi*4 +: 4]),
        .y     (y[gi*4 +: 4]),
        .cin   (slice_c[gi]),
        .sum   (sum[gi*4 +: 4]),
        .cout  (slice_cout[gi]),
        .grp_p (slice_p[gi]),
        .grp_g (slice_g[gi])
      );
      // Next slice carry from group terms; equals slice_cout[gi] logically.
      assign slice_c[gi+1] = slice_g[gi] | (slice_p[gi] & slice_c[gi]);
    end
  endgenerate

  // Take the carry-out from the last slice's own lookahead output.
  assign cout = slice_cout[NSLICE-1];

endmodule

// ---------------------------------------------------------------------------
// Top level: IDLE -> RUN (WIDTH steps) -> DONE (one cycle) FSM with the
// accumulator datapath. The upper half of acc holds the running partial sum,
// the lower half holds the not-yet-consumed multiplier bits.
// ---------------------------------------------------------------------------
module mult_shift_add #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CW-1:0]      count_q;
  logic               busy_q;
  logic               done_q;
  logic [2*WIDTH-1:0] product_q;

  logic [WIDTH-1:0]   addend_d;
  logic [WIDTH-1:0]   sum_d;
  logic               cout_d;
  logic [2*WIDTH-1:0] acc_d;

  // Add the multiplicand only when the current multiplier bit is set.
  always_comb begin
    addend_d = acc_q[0] ? mcand_q : '0;
  end

  cla_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .x    (acc_q[2*WIDTH-1:WIDTH]),
    .y    (addend_d),
    .cin  (1'b0),
    .sum  (sum_d),
    .cout (cout_d)
  );

  // Shift right by one, pulling the adder carry into the top bit.
  always_comb begin
    acc_d = {cout_d, sum_d, acc_q[WIDTH-1:1]};
  end

  // Control FSM and datapath registers; busy/done/product are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            mcand_q <= a;
            acc_q   <= {{WIDTH{1'b0}}, b};
            count_q <= '0;
            state_q <= S_RUN;
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
          end
        end

        S_RUN: begin
          // start is deliberately ignored here; operands stay latched.
          acc_q <= acc_d;
          if (count_q == LAST_STEP) begin
            product_q <= acc_d;
            count_q   <= '0;
            state_q   <= S_DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
          end else begin
            count_q   <= count_q + 1'b1;
          end
        end

        S_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            // Back-to-back accept: same latch as from IDLE.
            mcand_q <= a;
            acc_q   <= {{WIDTH{1'b0}}, b};
            count_q <= '0;
            state_q <= S_RUN;
            busy_q  <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          // Unused encoding: fall back to a quiet IDLE.
          state_q <= S_IDLE;
          count_q <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule
